noc_switch_allocator: RTL and testbench

//  Wormhole switch allocator for the 5-port mesh router. Takes each input queue's one-hot output request
//  (from the per-queue address generators), arbitrates per output port with round-robin fairness,

---
 rtl/noc_pkg.sv | 45 ++++
 rtl/noc_switch_allocator_checker.sv | 40 ++++
 rtl/rr_arbiter.sv | 29 ++
 rtl/noc_switch_allocator.sv | 167 ++++++++++++++++
 tb/tb_noc_switch_allocator.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared types and helpers for the 5-port mesh router switch allocator.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PTR_W     = 3;

  typedef enum logic [PTR_W-1:0] {
    P_N = 3'd0,
    P_S = 3'd1,
    P_E = 3'd2,
    P_W = 3'd3,
    P_L = 3'd4
  } port_e;

  typedef logic [NUM_PORTS-1:0] port_vec_t;

  typedef enum logic [1:0] {
    IN_FREE  = 2'd0,
    IN_BOUND = 2'd1,
    IN_DROP  = 2'd2
  } in_state_e;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_e;

  function automatic logic is_onehot(input port_vec_t v);
    return (v != {NUM_PORTS{1'b0}}) && ((v & (v - port_vec_t'(1))) == {NUM_PORTS{1'b0}});
  endfunction

  function automatic logic [PTR_W-1:0] onehot_to_idx(input port_vec_t v);
    logic [PTR_W-1:0] idx;
    idx = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (v[k]) begin
        idx = PTR_W'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_switch_allocator_checker.sv
// Invariants of the switch allocator crossbar selects and queue pops.
module noc_switch_allocator_checker
  import noc_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  input port_vec_t [NUM_PORTS-1:0] xbar_sel,
  input port_vec_t                 pop,
  input port_vec_t                 in_valid
);

  logic sel_ok_s;
  logic col_ok_s;

  // Each output selects at most one input and no input feeds two outputs
  always_comb begin
    sel_ok_s = 1'b1;
    col_ok_s = 1'b1;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if ((xbar_sel[o] != {NUM_PORTS{1'b0}}) && !is_onehot(xbar_sel[o])) begin
        sel_ok_s = 1'b0;
      end else begin
        sel_ok_s = sel_ok_s;
      end
      for (int p = o + 1; p < NUM_PORTS; p++) begin
        if ((xbar_sel[o] & xbar_sel[p]) != {NUM_PORTS{1'b0}}) begin
          col_ok_s = 1'b0;
        end else begin
          col_ok_s = col_ok_s;
        end
      end
    end
  end

  a_sel_onehot: assert property (@(posedge clk) disable iff (rst) sel_ok_s);
  a_sel_unique: assert property (@(posedge clk) disable iff (rst) col_ok_s);
  a_pop_valid:  assert property (@(posedge clk) disable iff (rst)
                                 ((pop & ~in_valid) == {NUM_PORTS{1'b0}}));

endmodule

// File: rtl/rr_arbiter.sv
// Combinational 5-way round-robin arbiter: grants the first requester after ptr, cyclically.
module rr_arbiter
  import noc_pkg::*;
(
  input  port_vec_t        req,
  input  logic [PTR_W-1:0] ptr,
  output port_vec_t        grant
);

  logic             found_s;
  logic [PTR_W-1:0] idx_s;

  // Scan starting just after ptr so the previous owner has lowest priority
  always_comb begin
    grant   = {NUM_PORTS{1'b0}};
    found_s = 1'b0;
    idx_s   = {PTR_W{1'b0}};
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx_s = PTR_W'((int'(ptr) + k) % NUM_PORTS);
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Wormhole switch allocator: per-output round-robin arbitration with header-to-tail locking,
// per-input bind/drop tracking, crossbar selects and queue pops.
module noc_switch_allocator
  import noc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  port_vec_t                 in_valid_i,
  input  port_vec_t [NUM_PORTS-1:0] in_req_i,
  input  port_vec_t                 in_tail_i,
  input  port_vec_t                 out_ready_i,
  output port_vec_t [NUM_PORTS-1:0] xbar_sel_o,
  output port_vec_t                 out_valid_o,
  output port_vec_t                 pop_o,
  output port_vec_t                 drop_o
);

  out_state_e                out_state_r   [NUM_PORTS];
  out_state_e                out_state_nxt_s [NUM_PORTS];
  in_state_e                 in_state_r    [NUM_PORTS];
  in_state_e                 in_state_nxt_s  [NUM_PORTS];
  logic [PTR_W-1:0]          ptr_r         [NUM_PORTS];
  logic [PTR_W-1:0]          ptr_nxt_s     [NUM_PORTS];
  port_vec_t [NUM_PORTS-1:0] xbar_sel_r;
  port_vec_t [NUM_PORTS-1:0] sel_nxt_s;
  port_vec_t [NUM_PORTS-1:0] elig_s;
  port_vec_t [NUM_PORTS-1:0] grant_s;
  port_vec_t                 xfer_s;
  port_vec_t                 out_tail_s;
  port_vec_t                 lock_pop_s;
  port_vec_t                 granted_s;
  port_vec_t                 drop_s;

  // Eligible requesters per idle output: free inputs with a valid one-hot route to that output
  always_comb begin
    elig_s = {(NUM_PORTS*NUM_PORTS){1'b0}};
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        elig_s[o][i] = in_valid_i[i] && (in_state_r[i] == IN_FREE) && is_onehot(in_req_i[i])
                       && in_req_i[i][o] && (out_state_r[o] == OUT_IDLE);
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter u_arb (
      .req   (elig_s[g]),
      .ptr   (ptr_r[g]),
      .grant (grant_s[g])
    );
  end

  // Flit transfers through locked outputs and the input-side view of them
  always_comb begin
    xfer_s     = {NUM_PORTS{1'b0}};
    out_tail_s = {NUM_PORTS{1'b0}};
    lock_pop_s = {NUM_PORTS{1'b0}};
    granted_s  = {NUM_PORTS{1'b0}};
    drop_s     = {NUM_PORTS{1'b0}};
    for (int o = 0; o < NUM_PORTS; o++) begin
      xfer_s[o]     = (out_state_r[o] == OUT_LOCKED) && ((xbar_sel_r[o] & in_valid_i) != {NUM_PORTS{1'b0}})
                      && out_ready_i[o];
      out_tail_s[o] = (xbar_sel_r[o] & in_tail_i) != {NUM_PORTS{1'b0}};
      lock_pop_s    = lock_pop_s | (xbar_sel_r[o] & {NUM_PORTS{xfer_s[o]}});
      granted_s     = granted_s | grant_s[o];
      drop_s[o]     = (in_state_r[o] == IN_DROP) && in_valid_i[o];
    end
  end

  // Output FSMs: lock on grant, release on transferred tail and rotate priority past the owner
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_state_nxt_s[o] = out_state_r[o];
      sel_nxt_s[o]       = xbar_sel_r[o];
      ptr_nxt_s[o]       = ptr_r[o];
      case (out_state_r[o])
        OUT_IDLE: begin
          if (grant_s[o] != {NUM_PORTS{1'b0}}) begin
            out_state_nxt_s[o] = OUT_LOCKED;
            sel_nxt_s[o]       = grant_s[o];
          end else begin
            out_state_nxt_s[o] = OUT_IDLE;
          end
        end
        OUT_LOCKED: begin
          if (xfer_s[o] && out_tail_s[o]) begin
            out_state_nxt_s[o] = OUT_IDLE;
            sel_nxt_s[o]       = {NUM_PORTS{1'b0}};
            ptr_nxt_s[o]       = onehot_to_idx(xbar_sel_r[o]);
          end else begin
            out_state_nxt_s[o] = OUT_LOCKED;
          end
        end
        default: begin
          out_state_nxt_s[o] = OUT_IDLE;
          sel_nxt_s[o]       = {NUM_PORTS{1'b0}};
        end
      endcase
    end
  end

  // Input FSMs: bind on grant, drop unroutable packets until their tail leaves
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_state_nxt_s[i] = in_state_r[i];
      case (in_state_r[i])
        IN_FREE: begin
          if (granted_s[i]) begin
            in_state_nxt_s[i] = IN_BOUND;
          end else if (in_valid_i[i] && !is_onehot(in_req_i[i])) begin
            in_state_nxt_s[i] = IN_DROP;
          end else begin
            in_state_nxt_s[i] = IN_FREE;
          end
        end
        IN_BOUND: begin
          if (lock_pop_s[i] && in_tail_i[i]) begin
            in_state_nxt_s[i] = IN_FREE;
          end else begin
            in_state_nxt_s[i] = IN_BOUND;
          end
        end
        IN_DROP: begin
          if (in_valid_i[i] && in_tail_i[i]) begin
            in_state_nxt_s[i] = IN_FREE;
          end else begin
            in_state_nxt_s[i] = IN_DROP;
          end
        end
        default: in_state_nxt_s[i] = IN_FREE;
      endcase
    end
  end

  // State registers; pointers reset to the last port so input 0 is favoured first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_state_r[p] <= OUT_IDLE;
        in_state_r[p]  <= IN_FREE;
        ptr_r[p]       <= PTR_W'(NUM_PORTS - 1);
        xbar_sel_r[p]  <= {NUM_PORTS{1'b0}};
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_state_r[p] <= out_state_nxt_s[p];
        in_state_r[p]  <= in_state_nxt_s[p];
        ptr_r[p]       <= ptr_nxt_s[p];
        xbar_sel_r[p]  <= sel_nxt_s[p];
      end
    end
  end

  assign xbar_sel_o  = xbar_sel_r;
  assign out_valid_o = xfer_s;
  assign drop_o      = drop_s;
  assign pop_o       = lock_pop_s | drop_s;

  noc_switch_allocator_checker u_chk (
    .clk      (clk),
    .rst      (rst),
    .xbar_sel (xbar_sel_r),
    .pop      (pop_o),
    .in_valid (in_valid_i)
  );

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model of the allocator.
module tb_noc_switch_allocator;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       in_valid, in_tail, out_ready;
  logic [4:0][4:0]  in_req;
  logic [4:0][4:0]  xbar_sel;
  logic [4:0]       out_valid, pop, drop;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner per output (-1 idle), rr pointer, input state (0 free, 1 bound, 2 drop)
  int m_owner [5];
  int m_ptr   [5];
  int m_in    [5];

  always #5 clk = ~clk;

  noc_switch_allocator dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_req_i    (in_req),
    .in_tail_i   (in_tail),
    .out_ready_i (out_ready),
    .xbar_sel_o  (xbar_sel),
    .out_valid_o (out_valid),
    .pop_o       (pop),
    .drop_o      (drop)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [4:0] v);
    return $countones(v) == 1;
  endfunction

  task automatic model_reset;
    for (int p = 0; p < 5; p++) begin
      m_owner[p] = -1;
      m_ptr[p]   = 4;
      m_in[p]    = 0;
    end
  endtask

  task automatic model_expect(output logic [4:0][4:0] e_sel, output logic [4:0] e_ov,
                              output logic [4:0] e_pop, output logic [4:0] e_drop);
    e_sel = '0; e_ov = '0; e_pop = '0; e_drop = '0;
    for (int o = 0; o < 5; o++) begin
      if (m_owner[o] >= 0) begin
        e_sel[o][m_owner[o]] = 1'b1;
        if (in_valid[m_owner[o]] && out_ready[o]) begin
          e_ov[o] = 1'b1;
          e_pop[m_owner[o]] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (m_in[i] == 2 && in_valid[i]) begin
        e_drop[i] = 1'b1;
        e_pop[i]  = 1'b1;
      end
    end
  endtask

  task automatic model_step;
    int win [5];
    int pre [5];
    int ow;
    pre = m_in;
    for (int o = 0; o < 5; o++) begin
      win[o] = -1;
      if (m_owner[o] < 0) begin
        for (int k = 1; k <= 5; k++) begin
          int c;
          c = (m_ptr[o] + k) % 5;
          if (win[o] < 0 && in_valid[c] && pre[c] == 0 && legal(in_req[c]) && in_req[c][o])
            win[o] = c;
        end
      end
    end
    for (int o = 0; o < 5; o++) begin
      if (m_owner[o] >= 0) begin
        ow = m_owner[o];
        if (in_valid[ow] && out_ready[o] && in_tail[ow]) begin
          m_in[ow]   = 0;
          m_ptr[o]   = ow;
          m_owner[o] = -1;
        end
      end else if (win[o] >= 0) begin
        m_owner[o]   = win[o];
        m_in[win[o]] = 1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (pre[i] == 0 && m_in[i] == 0 && in_valid[i] && !legal(in_req[i])) m_in[i] = 2;
      else if (pre[i] == 2 && in_valid[i] && in_tail[i]) m_in[i] = 0;
    end
  endtask

  // Called at a negedge: apply inputs, let them settle, compare against the model
  task automatic drive(input logic [4:0] v, input logic [4:0][4:0] r, input logic [4:0] t,
                       input logic [4:0] rd);
    logic [4:0][4:0] e_sel;
    logic [4:0]      e_ov, e_pop, e_drop;
    in_valid = v; in_req = r; in_tail = t; out_ready = rd;
    #1;
    model_expect(e_sel, e_ov, e_pop, e_drop);
    check("xbar_sel",  32'(xbar_sel),  32'(e_sel));
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("pop",       32'(pop),       32'(e_pop));
    check("drop",      32'(drop),      32'(e_drop));
  endtask

  task automatic tick;
    @(posedge clk);
    model_step;
    @(negedge clk);
  endtask

  initial begin
    logic [4:0][4:0] r;
    logic [4:0]      v, t, rd;

    rst = 1'b1; in_valid = '0; in_req = '0; in_tail = '0; out_ready = '0;
    model_reset;
    @(negedge clk);
    #1;
    check("rst_sel", 32'(xbar_sel), 32'd0);
    check("rst_pop", 32'(pop), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single-flit L -> N
    r = '0; r[4] = 5'b00001;
    drive(5'b10000, r, 5'b10000, 5'b11111); tick;
    drive(5'b10000, r, 5'b10000, 5'b11111);
    check("t1_sel", 32'(xbar_sel[0]), 32'h10);
    check("t1_ov",  32'(out_valid[0]), 32'd1);
    check("t1_pop", 32'(pop[4]), 32'd1);
    tick;
    drive(5'b00000, r, 5'b00000, 5'b11111);
    check("t1_rel", 32'(xbar_sel[0]), 32'd0);
    tick;

    // 6: N -> L single flit moves ptr[L] to N, then reset in the middle of W -> S
    r = '0; r[0] = 5'b10000;
    drive(5'b00001, r, 5'b00001, 5'b11111); tick;
    drive(5'b00001, r, 5'b00001, 5'b11111); tick;
    r = '0; r[3] = 5'b00010;
    drive(5'b01000, r, 5'b00000, 5'b11111); tick;
    drive(5'b01000, r, 5'b00000, 5'b11111);
    check("t6_pre_pop", 32'(pop[3]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_sel", 32'(xbar_sel), 32'd0);
    check("t6_pop", 32'(pop), 32'd0);
    check("t6_ov",  32'(out_valid), 32'd0);
    model_reset;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 2: N and E both request L with 3-flit packets; reset pointer favours N
    r = '0; r[0] = 5'b10000; r[2] = 5'b10000;
    for (int c = 0; c < 9; c++) begin
      v  = (c <= 7) ? 5'b00100 : 5'b00000;
      v  = v | ((c <= 3) ? 5'b00001 : 5'b00000);
      t  = ((c == 3) ? 5'b00001 : 5'b00000) | ((c == 7) ? 5'b00100 : 5'b00000);
      drive(v, r, t, 5'b11111);
      if (c == 1) check("t2_n_wins", 32'(xbar_sel[4]), 32'h01);
      if (c == 4) check("t2_gap",    32'(xbar_sel[4]), 32'h00);
      if (c == 5) check("t2_e_next", 32'(xbar_sel[4]), 32'h04);
      tick;
    end

    // 3: W -> S, backpressure mid-packet
    r = '0; r[3] = 5'b00010;
    for (int c = 0; c < 10; c++) begin
      v  = (c <= 8) ? 5'b01000 : 5'b00000;
      t  = (c == 8) ? 5'b01000 : 5'b00000;
      rd = (c >= 2 && c <= 5) ? 5'b11101 : 5'b11111;
      drive(v, r, t, rd);
      if (c == 3) begin
        check("t3_hold_sel", 32'(xbar_sel[1]), 32'h08);
        check("t3_no_pop",   32'(pop[3]), 32'd0);
      end
      if (c == 6) check("t3_resume", 32'(out_valid[1]), 32'd1);
      tick;
    end

    // 4: E with no route drops a 2-flit packet, next packet routes to N
    for (int c = 0; c < 6; c++) begin
      r = '0;
      r[2] = (c >= 3) ? 5'b00001 : 5'b00000;
      v  = (c <= 4) ? 5'b00100 : 5'b00000;
      t  = (c == 2 || c == 4) ? 5'b00100 : 5'b00000;
      drive(v, r, t, 5'b11111);
      if (c == 1) begin
        check("t4_drop1", 32'(drop[2]), 32'd1);
        check("t4_nosel", 32'(xbar_sel), 32'd0);
      end
      if (c == 2) check("t4_drop2", 32'(drop[2]), 32'd1);
      if (c == 4) check("t4_route", 32'(xbar_sel[0]), 32'h04);
      tick;
    end

    // 5: three disjoint connections in parallel
    r = '0; r[0] = 5'b00100; r[1] = 5'b01000; r[4] = 5'b00001;
    for (int c = 0; c < 3; c++) begin
      v = (c < 2) ? 5'b10011 : 5'b00000;
      drive(v, r, 5'b10011, 5'b11111);
      if (c == 1) begin
        check("t5_sel_e", 32'(xbar_sel[2]), 32'h01);
        check("t5_sel_w", 32'(xbar_sel[3]), 32'h02);
        check("t5_sel_n", 32'(xbar_sel[0]), 32'h10);
        check("t5_pops",  32'(pop), 32'h13);
      end
      tick;
    end

    // Randomized traffic, with one asynchronous reset in the middle
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 9) < 8) r[i] = 5'(5'b00001 << $urandom_range(0, 4));
        else                          r[i] = 5'($urandom);
        v[i]  = ($urandom_range(0, 9) < 8);
        t[i]  = ($urandom_range(0, 9) < 3);
        rd[i] = ($urandom_range(0, 9) < 7);
      end
      drive(v, r, t, rd);
      if (c == 400) begin
        #2 rst = 1'b1;
        #1;
        check("rnd_rst_sel", 32'(xbar_sel), 32'd0);
        check("rnd_rst_pop", 32'(pop), 32'd0);
        model_reset;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        tick;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
